// File: rtl/canny_pixel_source_pkg.sv
// -----------------------------------------------------------------------------
// canny_pixel_source_pkg
// Shared definitions for the canny edge-detection stages: default frame
// geometry, the pixel-source state encoding and a counter-width helper.
// No ports (package).
// -----------------------------------------------------------------------------
package canny_pixel_source_pkg;

    // Default frame geometry shared by every canny stage.
    localparam int CANNY_WIDTH      = 640;
    localparam int CANNY_DEPTH      = 506;
    localparam int CANNY_DATA_WIDTH = 16;

    // Pixel-source sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRIME,
        ST_STREAM,
        ST_HBLANK,
        ST_FLUSH,
        ST_DONE
    } canny_src_state_e;

    // Bits needed for a counter that must be able to hold max_val.
    function automatic int cnt_width(input int max_val);
        if (max_val < 2) return 1;
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/canny_pixel_source.sv
// -----------------------------------------------------------------------------
// canny_pixel_source
// Streams one frame from a synchronous frame buffer into the 3x3 window
// generator: primes the window, reads the frame row by row with horizontal
// blanking between rows, then pushes zero pixels to drain the line buffers.
//
// Ports
//   clk        : sole clock, rising edge
//   rst_n      : asynchronous active-low reset
//   frame_go   : single-cycle request to stream one frame (honoured in IDLE)
//   en_fun     : function enable; low aborts streaming
//   pause      : downstream stall; no new pixel is issued while high
//   mem_rd_en  : frame-buffer read strobe
//   mem_addr   : frame-buffer read address
//   mem_rdata  : read data, valid one cycle after mem_rd_en
//   start      : frame-active level to the window generator
//   data_en    : pixel strobe to the window generator
//   pix_out    : pixel to the window generator
//   busy       : high whenever the sequencer is not idle
//   frame_done : single-cycle pulse at end of frame
// -----------------------------------------------------------------------------
module canny_pixel_source
    import canny_pixel_source_pkg::*;
#(
    parameter int WIDTH      = CANNY_WIDTH,
    parameter int DEPTH      = CANNY_DEPTH,
    parameter int DATA_WIDTH = CANNY_DATA_WIDTH,
    parameter int ADDR_WIDTH = 19,
    parameter int PRIME_CYC  = 3,
    parameter int H_BLANK    = 4,
    parameter int FLUSH_PIX  = WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_go,
    input  logic                  en_fun,
    input  logic                  pause,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  start,
    output logic                  data_en,
    output logic [DATA_WIDTH-1:0] pix_out,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int COL_W   = cnt_width(WIDTH - 1);
    localparam int ROW_W   = cnt_width(DEPTH);
    localparam int PRIME_W = cnt_width(PRIME_CYC - 1);
    localparam int BLANK_W = cnt_width(H_BLANK - 1);
    localparam int FLUSH_W = cnt_width(FLUSH_PIX);

    localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(DEPTH - 1);
    localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(PRIME_CYC - 1);
    localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(H_BLANK - 1);
    localparam logic [FLUSH_W-1:0] FLUSH_END  = FLUSH_W'(FLUSH_PIX);

    canny_src_state_e      state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [COL_W-1:0]      col_q;
    logic [ROW_W-1:0]      row_q;
    logic [PRIME_W-1:0]    prime_q;
    logic [BLANK_W-1:0]    blank_q;
    logic [FLUSH_W-1:0]    flush_q;   // flush strobes issued so far
    logic                  start_q;
    logic                  busy_q;
    logic                  frame_done_q;
    logic                  data_en_q;
    logic                  pix_sel_q; // current data_en carries a memory pixel

    logic rd_issue;
    logic flush_issue;

    // pause must stop a read in the same cycle, so the strobe is decoded
    // from state rather than registered. en_fun is deliberately not used
    // here: a read in the abort cycle is dropped at data_en instead.
    assign rd_issue    = (state_q == ST_STREAM) && !pause;
    assign flush_issue = (state_q == ST_FLUSH) && !pause && (flush_q != FLUSH_END);

    assign mem_rd_en  = rd_issue;
    assign mem_addr   = addr_q;
    assign start      = start_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign data_en    = data_en_q;

    // The buffer's read data arrives in the data_en cycle itself, so the
    // pixel is selected by a registered flag instead of being re-registered;
    // flush strobes and idle cycles present zero.
    assign pix_out = pix_sel_q ? mem_rdata : '0;

    // NOTE: every register here uses non-blocking assignment so that all
    // next-state values are computed from the same pre-edge snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            col_q        <= '0;
            row_q        <= '0;
            prime_q      <= '0;
            blank_q      <= '0;
            flush_q      <= '0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            data_en_q    <= 1'b0;
            pix_sel_q    <= 1'b0;
        end else begin
            data_en_q <= (rd_issue || flush_issue) && en_fun;
            pix_sel_q <= rd_issue && en_fun;

            if ((state_q != ST_IDLE) && !en_fun) begin
                state_q      <= ST_IDLE;
                start_q      <= 1'b0;
                busy_q       <= 1'b0;
                frame_done_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (frame_go && en_fun) begin
                            addr_q  <= '0;
                            col_q   <= '0;
                            row_q   <= '0;
                            prime_q <= '0;
                            blank_q <= '0;
                            flush_q <= '0;
                            start_q <= 1'b1;
                            busy_q  <= 1'b1;
                            state_q <= ST_PRIME;
                        end
                    end

                    ST_PRIME: begin
                        if (prime_q == PRIME_LAST) begin
                            prime_q <= '0;
                            state_q <= ST_STREAM;
                        end else begin
                            prime_q <= prime_q + 1'b1;
                        end
                    end

                    ST_STREAM: begin
                        if (!pause) begin
                            addr_q <= addr_q + 1'b1;
                            if (col_q == COL_LAST) begin
                                col_q <= '0;
                                row_q <= row_q + 1'b1;
                                if (row_q == ROW_LAST) begin
                                    flush_q <= '0;
                                    state_q <= ST_FLUSH;
                                end else begin
                                    blank_q <= '0;
                                    state_q <= ST_HBLANK;
                                end
                            end else begin
                                col_q <= col_q + 1'b1;
                            end
                        end
                    end

                    // Blanking is a fixed gap and ignores pause.
                    ST_HBLANK: begin
                        if (blank_q == BLANK_LAST) begin
                            state_q <= ST_STREAM;
                        end else begin
                            blank_q <= blank_q + 1'b1;
                        end
                    end

                    // Leave only once the final zero strobe is on data_en,
                    // so frame_done lands in the cycle after it.
                    ST_FLUSH: begin
                        if (flush_issue) begin
                            flush_q <= flush_q + 1'b1;
                        end
                        if (data_en_q && (flush_q == FLUSH_END)) begin
                            start_q      <= 1'b0;
                            frame_done_q <= 1'b1;
                            state_q      <= ST_DONE;
                        end
                    end

                    ST_DONE: begin
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end

                    default: begin
                        start_q      <= 1'b0;
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_canny_pixel_source.sv
// -----------------------------------------------------------------------------
// tb_canny_pixel_source
// Scoreboard bench for canny_pixel_source on a 4x3 frame. Stimulus pushes the
// expected address and pixel streams; a negedge monitor pops and compares on
// every mem_rd_en / data_en. Frame timing is checked against offsets derived
// from the frame geometry.
// -----------------------------------------------------------------------------
module tb_canny_pixel_source;

    localparam int W    = 4;
    localparam int D    = 3;
    localparam int HB   = 2;
    localparam int PC   = 3;
    localparam int FP   = 5;
    localparam int DW   = 16;
    localparam int AW   = 19;
    localparam int NPIX = W * D;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_go = 1'b0;
    logic          en_fun = 1'b1;
    logic          pause = 1'b0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic          start;
    logic          data_en;
    logic [DW-1:0] pix_out;
    logic          busy;
    logic          frame_done;

    canny_pixel_source #(
        .WIDTH(W), .DEPTH(D), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .PRIME_CYC(PC), .H_BLANK(HB), .FLUSH_PIX(FP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_go(frame_go), .en_fun(en_fun),
        .pause(pause), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .start(start), .data_en(data_en),
        .pix_out(pix_out), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous frame buffer whose contents equal the address; garbage
    // when not read so stale-data timing errors show up.
    always @(posedge clk) mem_rdata <= mem_rd_en ? mem_addr[DW-1:0] : DW'($urandom);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input longint actual, input longint expected);
        n_tests++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Scoreboard state
    int   exp_addr_q[$];
    int   exp_pix_q[$];
    int   de_log[$];
    int   fd_count   = 0;
    int   fd_cyc     = -1;
    int   start_rise = -1;
    int   start_fall = -1;
    logic start_prev = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd_en) begin
                check("no_read_while_paused", pause, 0);
                if (exp_addr_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_read: addr %0d, none expected", mem_addr);
                end else begin
                    check("mem_addr", mem_addr, exp_addr_q.pop_front());
                end
            end
            if (data_en) begin
                de_log.push_back(cyc);
                if (exp_pix_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_data_en: pix %0d, none expected", pix_out);
                end else begin
                    check("pix_out", pix_out, exp_pix_q.pop_front());
                end
            end
            if (frame_done) begin
                fd_count++;
                fd_cyc = cyc;
            end
            if (start && !start_prev) start_rise = cyc;
            if (!start && start_prev) start_fall = cyc;
            start_prev = start;
        end
    end

    // Reference: a frame reads every address once in order, then emits FP zeros.
    task automatic begin_frame();
        de_log.delete();
        exp_addr_q.delete();
        exp_pix_q.delete();
        for (int a = 0; a < NPIX; a++) begin
            exp_addr_q.push_back(a);
            exp_pix_q.push_back(a);
        end
        for (int j = 0; j < FP; j++) exp_pix_q.push_back(0);
    endtask

    task automatic pulse_go(output int go_cyc);
        go_cyc   = cyc;
        frame_go = 1'b1;
        @(posedge clk); #1;
        frame_go = 1'b0;
    endtask

    task automatic run_until_done(input string tag, input int budget, input bit rnd_pause,
                                  input bit spam_go);
        int fd0 = fd_count;
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (fd_count != fd0) begin
                seen = 1'b1;
                break;
            end
            pause    = rnd_pause ? ($urandom_range(0, 2) == 0) : 1'b0;
            frame_go = spam_go ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        pause    = 1'b0;
        frame_go = 1'b0;
        check({tag, "_frame_done_in_budget"}, seen, 1);
    endtask

    task automatic wait_read(input int addr, input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (mem_rd_en && (mem_addr == AW'(addr))) begin
                found = 1'b1;
                break;
            end
        end
        check($sformatf("reached_read_%0d", addr), found, 1);
    endtask

    // Expected data_en offset from the start rise for strobe k, unpaused.
    function automatic int exp_de_off(input int k);
        int last_pix = PC + 1 + (NPIX - 1) + (D - 1) * HB;
        if (k < NPIX) return PC + 1 + k + (k / W) * HB;
        return last_pix + 1 + (k - NPIX);
    endfunction

    task automatic check_frame_timing(input string tag);
        int bad = 0;
        check({tag, "_de_count"}, de_log.size(), NPIX + FP);
        for (int k = 0; k < de_log.size(); k++) begin
            if (de_log[k] - start_rise != exp_de_off(k)) bad++;
        end
        check({tag, "_de_timing_errors"}, bad, 0);
        check({tag, "_frame_done_cycle"}, fd_cyc - start_rise, exp_de_off(NPIX + FP - 1) + 1);
        check({tag, "_addr_q_drained"}, exp_addr_q.size(), 0);
        check({tag, "_pix_q_drained"}, exp_pix_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int go_cyc;
        int fd0;
        int fall;
        bit hit;

        // Reset state
        #12;
        check("rst_start", start, 0);
        check("rst_data_en", data_en, 0);
        check("rst_mem_rd_en", mem_rd_en, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_pix_out", pix_out, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // frame_go with en_fun low is ignored
        en_fun = 1'b0;
        pulse_go(go_cyc);
        @(negedge clk);
        check("go_without_en_fun_busy", busy, 0);
        en_fun = 1'b1;
        @(posedge clk); #1;

        // Basic frame, no pause
        begin_frame();
        pulse_go(go_cyc);
        run_until_done("basic", 200, 1'b0, 1'b0);
        check("basic_start_rise", start_rise - go_cyc, 1);
        check_frame_timing("basic");
        check("basic_idle_start", start, 0);

        // Pause for 3 cycles when address 5 is being presented
        begin_frame();
        pulse_go(go_cyc);
        wait_read(5, 100);
        pause = 1'b1;
        repeat (3) @(posedge clk);
        #1 pause = 1'b0;
        run_until_done("pause3", 200, 1'b0, 1'b0);
        check("pause3_de_count", de_log.size(), NPIX + FP);
        if (de_log.size() > 5) check("pause3_hole", de_log[5] - de_log[4], 4);

        // Random pause over whole frames
        for (int f = 0; f < 3; f++) begin
            begin_frame();
            pulse_go(go_cyc);
            run_until_done($sformatf("rnd%0d", f), 600, 1'b1, 1'b0);
            check($sformatf("rnd%0d_de_count", f), de_log.size(), NPIX + FP);
            check($sformatf("rnd%0d_drained", f), exp_pix_q.size(), 0);
        end

        // frame_go pulsed while busy is ignored
        fd0 = fd_count;
        begin_frame();
        pulse_go(go_cyc);
        run_until_done("spam", 200, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("spam_frame_done_count", fd_count - fd0, 1);
        check("spam_busy_after", busy, 0);
        check_frame_timing("spam");

        // en_fun dropped during row 1
        begin_frame();
        pulse_go(go_cyc);
        fd0 = fd_count;
        wait_read(6, 100);
        en_fun = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_start", start, 0);
        check("abort_busy", busy, 0);
        check("abort_data_en", data_en, 0);
        check("abort_mem_rd_en", mem_rd_en, 0);
        check("abort_frame_done", frame_done, 0);
        exp_addr_q.delete();
        exp_pix_q.delete();
        en_fun = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_frame_done", fd_count, fd0);
        check("abort_idle_busy", busy, 0);
        begin_frame();
        pulse_go(go_cyc);
        run_until_done("restart", 200, 1'b0, 1'b0);
        check_frame_timing("restart");

        // Reset asserted during FLUSH
        fd0 = fd_count;
        begin_frame();
        pulse_go(go_cyc);
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (de_log.size() >= NPIX + 2) begin
                hit = 1'b1;
                break;
            end
        end
        check("reached_flush", hit, 1);
        #2 rst_n = 1'b0;
        #1;
        check("flush_rst_start", start, 0);
        check("flush_rst_data_en", data_en, 0);
        check("flush_rst_mem_rd_en", mem_rd_en, 0);
        check("flush_rst_busy", busy, 0);
        check("flush_rst_frame_done", frame_done, 0);
        check("flush_rst_mem_addr", mem_addr, 0);
        check("flush_rst_pix_out", pix_out, 0);
        exp_addr_q.delete();
        exp_pix_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("flush_rst_idle_busy", busy, 0);
        check("flush_rst_idle_start", start, 0);
        check("flush_rst_no_frame_done", fd_count, fd0);

        // Back-to-back frames
        begin_frame();
        pulse_go(go_cyc);
        run_until_done("b2b_1", 200, 1'b0, 1'b0);
        check_frame_timing("b2b_1");
        fall = start_fall;
        begin_frame();
        pulse_go(go_cyc);
        run_until_done("b2b_2", 200, 1'b0, 1'b0);
        check_frame_timing("b2b_2");
        check("b2b_start_low_cycles", start_rise - fall, 2);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
